// File: rtl/mac_result_drain.sv
// mac_result_drain: captures finished BLOCK_SIZE x BLOCK_SIZE result blocks into a
// block-wide circular FIFO and streams them out one element per cycle in
// row-major order over a valid/ready handshake.
// Optional feature macro: MAC_RESULT_RELU_EN (zero negative elements at the output).
module mac_result_drain #(
  parameter int WIDTH      = 16,
  parameter int BLOCK_SIZE = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int IDXW      = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] in_data,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   out_data,
  output logic [IDXW-1:0]                    out_row,
  output logic [IDXW-1:0]                    out_col,
  output logic                               out_last,
  output logic [CW-1:0]                      level,
  output logic                               overflow_err
);

  localparam int NN = BLOCK_SIZE * BLOCK_SIZE;
  localparam int EW = (NN > 1) ? $clog2(NN) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [EW-1:0] E_LAST = EW'(NN - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [WIDTH*NN-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]       wp_r;
  logic [PW-1:0]       rp_r;
  logic [CW-1:0]       count_r;
  logic [CW-1:0]       count_next_s;
  logic [EW-1:0]       e_r;
  logic [0:0]          state_r;
  logic [0:0]          state_next_s;
  logic                overflow_r;

  logic                push_s;
  logic                fire_s;
  logic                pop_s;
  logic [WIDTH*NN-1:0] blk_s;
  logic [WIDTH-1:0]    elem_s [NN];
  logic [WIDTH-1:0]    sel_s;
  logic [WIDTH-1:0]    shaped_s;

  // Handshake qualifiers; a same-cycle pop never frees a slot for a push.
  assign in_ready  = (count_r != COUNT_FULL);
  assign out_valid = (state_r == STREAM);
  assign push_s    = in_valid & in_ready;
  assign fire_s    = out_valid & out_ready;
  assign pop_s     = fire_s & (e_r == E_LAST);
  assign level        = count_r;
  assign overflow_err = overflow_r;

  // Next occupancy from the push/pop pair; both together leave it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Drain FSM: stream whenever at least one block is (or will be) stored.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (count_next_s != {CW{1'b0}}) state_next_s = STREAM;
        else                            state_next_s = IDLE;
      end
      STREAM: begin
        if (count_next_s != {CW{1'b0}}) state_next_s = STREAM;
        else                            state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Control registers: pointers, occupancy, element index, FSM and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_r       <= {PW{1'b0}};
      rp_r       <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      e_r        <= {EW{1'b0}};
      state_r    <= IDLE;
      overflow_r <= 1'b0;
    end else begin
      count_r <= count_next_s;
      state_r <= state_next_s;
      if (push_s) wp_r <= wp_r + PW'(1);
      if (pop_s)  rp_r <= rp_r + PW'(1);
      if (fire_s) begin
        if (pop_s) e_r <= {EW{1'b0}};
        else       e_r <= e_r + EW'(1);
      end
      if (in_valid && !in_ready) overflow_r <= 1'b1;
    end
  end

  // Block storage; contents need no reset because out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wp_r] <= in_data;
  end

  // Unpack the head block: element 0 lives in the most significant slice.
  assign blk_s = mem_r[rp_r];
  for (genvar k = 0; k < NN; k++) begin : g_elem
    assign elem_s[k] = blk_s[(NN-1-k)*WIDTH +: WIDTH];
  end
  assign sel_s = elem_s[e_r];

  // Output shaping: optional ReLU on the selected element, stored data stays raw.
  always_comb begin
`ifdef MAC_RESULT_RELU_EN
    if (sel_s[WIDTH-1]) shaped_s = {WIDTH{1'b0}};
    else                shaped_s = sel_s;
`else
    shaped_s = sel_s;
`endif
  end

  // Output mux: zeros while idle so the bus rests at its reset values.
  always_comb begin
    out_data = {WIDTH{1'b0}};
    out_row  = {IDXW{1'b0}};
    out_col  = {IDXW{1'b0}};
    out_last = 1'b0;
    if (out_valid) begin
      out_data = shaped_s;
      out_row  = IDXW'(int'(e_r) / BLOCK_SIZE);
      out_col  = IDXW'(int'(e_r) % BLOCK_SIZE);
      out_last = (e_r == E_LAST);
    end else begin
      out_data = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain: directed scenarios plus a random
// phase, checked every cycle against a queue-of-blocks reference model.
module tb_mac_result_drain;

  localparam int W  = 16;
  localparam int N  = 2;
  localparam int NN = N * N;
  localparam int FD = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [63:0]   in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [0:0]    out_row;
  logic [0:0]    out_col;
  logic          out_last;
  logic [2:0]    level;
  logic          overflow_err;

  mac_result_drain #(.WIDTH(W), .BLOCK_SIZE(N), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .level(level), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO of whole blocks, position within the head block.
  logic [63:0] q[$];
  int          pos;
  bit          ovf;
  int          tests;
  int          fails;
  string       phase;

  function automatic logic [15:0] elem(input logic [63:0] blk, input int k);
    logic [63:0] sh;
    sh = blk >> ((NN - 1 - k) * W);
    return sh[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] ed;
    int sz;
    sz = q.size();
    chk("out_valid", 32'(out_valid), 32'(sz > 0));
    chk("level", 32'(level), 32'(sz));
    chk("in_ready", 32'(in_ready), 32'(sz < FD));
    chk("overflow_err", 32'(overflow_err), 32'(ovf));
    if (sz > 0) begin
      ed = elem(q[0], pos);
`ifdef MAC_RESULT_RELU_EN
      if (ed[15]) ed = 16'h0000;
`endif
      chk("out_data", 32'(out_data), 32'(ed));
      chk("out_row", 32'(out_row), 32'(pos / N));
      chk("out_col", 32'(out_col), 32'(pos % N));
      chk("out_last", 32'(out_last), 32'(pos == NN - 1));
    end else begin
      chk("out_data_idle", 32'(out_data), 32'd0);
      chk("out_row_idle", 32'(out_row), 32'd0);
      chk("out_col_idle", 32'(out_col), 32'd0);
      chk("out_last_idle", 32'(out_last), 32'd0);
    end
  endtask

  // One cycle: drive at negedge, check, then apply the model at the rising edge.
  task automatic step(input bit v, input logic [63:0] d, input bit r);
    int sz;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    check_all();
    sz = q.size();
    @(posedge clk);
    if (sz > 0 && r) begin
      if (pos == NN - 1) begin
        q.delete(0);
        pos = 0;
      end else begin
        pos++;
      end
    end
    if (v) begin
      if (sz < FD) q.push_back(d);
      else         ovf = 1'b1;
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd_blk();
    return {$urandom, $urandom};
  endfunction

  initial begin
    tests = 0; fails = 0; pos = 0; ovf = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0;
    phase = "reset";
    #3;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    phase = "single";
    step(1'b1, {16'h0100, 16'h0200, 16'h0300, 16'h0400}, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 1'b1);

    phase = "b2b";
    step(1'b1, rnd_blk(), 1'b1);
    step(1'b1, rnd_blk(), 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 64'd0, 1'b1);

    phase = "backpressure";
    step(1'b1, {16'h0100, 16'h0200, 16'h0300, 16'h0400}, 1'b1);
    step(1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 1'b1);

    phase = "fill";
    for (int i = 0; i < 4; i++) step(1'b1, rnd_blk(), 1'b0);
    phase = "overflow";
    step(1'b1, rnd_blk(), 1'b0);
    step(1'b0, 64'd0, 1'b0);
    phase = "drain";
    for (int i = 0; i < 18; i++) step(1'b0, 64'd0, 1'b1);

    phase = "push_on_pop";
    step(1'b1, rnd_blk(), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b1);
    step(1'b1, rnd_blk(), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 1'b1);

    phase = "midreset";
    step(1'b1, rnd_blk(), 1'b1);
    step(1'b1, rnd_blk(), 1'b1);
    step(1'b0, 64'd0, 1'b1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    q.delete();
    pos = 0;
    ovf = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    phase = "after_reset";
    step(1'b1, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 1'b1);

    phase = "relu";
    step(1'b1, {16'hFF00, 16'h0100, 16'h8000, 16'h7FFF}, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 1'b1);

    phase = "random";
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 2) == 0), rnd_blk(), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 20; i++) step(1'b0, 64'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_result_drain.md
# mac_result_drain

Downstream stage of the systolic MAC top level. It captures each finished BLOCK_SIZE×BLOCK_SIZE result block when the accumulator reports completion, and holds whole blocks in a small FIFO. It streams the results out one element per cycle, in row-major order, over a valid/ready handshake toward the write-back or activation logic.

## Interface
Parameters:
- WIDTH, 16, bit width of one fixed-point result element
- BLOCK_SIZE, 2, systolic array dimension; each block has BLOCK_SIZE*BLOCK_SIZE elements
- FIFO_DEPTH, 4, number of whole blocks buffered; power of two, ≥2

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  completion strobe, driven by the MAC accumulator_done
- in_data  input  WIDTH*BLOCK_SIZE*BLOCK_SIZE  packed result block; element k = r*BLOCK_SIZE+c at bits [(BLOCK_SIZE*BLOCK_SIZE-k)*WIDTH-1 -: WIDTH], so element 0 is in the MSBs
- in_ready  output  1  high when the FIFO is not full
- out_valid  output  1  out_data holds a valid element
- out_ready  input  1  consumer accepts the element
- out_data  output  WIDTH  current element
- out_row  output  $clog2(BLOCK_SIZE) (min 1)  row index of the current element
- out_col  output  $clog2(BLOCK_SIZE) (min 1)  column index of the current element
- out_last  output  1  current element is the last of its block
- level  output  $clog2(FIFO_DEPTH)+1  number of blocks stored, including the block being drained
- overflow_err  output  1  sticky; set when a block is offered while the FIFO is full

## Operation
- Storage is a block-wide circular buffer with write pointer wp, read pointer rp (both log2(FIFO_DEPTH) bits, wrapping) and count in 0..FIFO_DEPTH.
- Push: on in_valid & in_ready, store in_data at wp, then advance wp.
- in_valid while full: the block is dropped, overflow_err is set, and wp and count are unchanged.
- Drain state machine:
  - IDLE: count==0, so out_valid=0.
  - IDLE→STREAM when count becomes nonzero.
  - STREAM: element index e (0..N*N-1) selects an element of block[rp]. out_row = e / BLOCK_SIZE and out_col = e % BLOCK_SIZE. out_last = (e == N*N-1).
- On out_valid & out_ready:
  - If e < N*N-1, increment e.
  - If e == N*N-1, clear e, advance rp and pop the block.
  - After the pop, stay in STREAM if count-1 > 0; otherwise go to IDLE.
- Simultaneous push and final-element pop: count is unchanged and both pointers advance.
- Pushing while draining does not disturb the block being drained.
- out_data, out_row, out_col and out_last hold stable while out_valid=1 and out_ready=0.
- Data passes through without arithmetic; there are no width changes except under the macro below.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, level=0, overflow_err=0, e=0, wp=0, rp=0, state IDLE.
- Reset takes effect immediately, not at the next edge.
- Reset mid-drain discards all stored blocks, including a partially streamed one.
- Latency: a block pushed at edge T into an empty FIFO presents element 0 with out_valid=1 after edge T (registered; visible in cycle T+1).
- Throughput: one element per cycle while out_ready=1. There is no bubble between consecutive blocks; after the last element of block n, element 0 of block n+1 follows on the next cycle.
- in_ready = (count != FIFO_DEPTH) is combinational from registered count. A pop in the same cycle does not free a slot for a push until the next cycle.
- overflow_err is cleared only by rst.
- level updates on the edge following a push or pop.

## Configuration
- Macro: MAC_RESULT_RELU_EN.
- Defined: out_data = 0 whenever the selected stored element is negative (MSB set); otherwise it is passed unchanged. The ReLU is applied combinationally at the output mux and adds no latency. Stored data remains raw.
- Undefined: out_data is the stored element unchanged.

## Test plan
- Single block, BLOCK_SIZE=2, in_data = {16'h0100, 16'h0200, 16'h0300, 16'h0400}, out_ready=1:
  - Out in cycles T+1..T+4: 0100, 0200, 0300, 0400.
  - (row,col) = (0,0), (0,1), (1,0), (1,1).
  - out_last only with 0400; level returns to 0.
- Back-to-back blocks A and B pushed on consecutive edges, out_ready=1 -> 8 consecutive valid elements with no gap, A before B.
- Backpressure: out_ready=0 for 3 cycles during element 1 -> out_data stays 0200 and e does not advance. It resumes at 0300 once out_ready=1.
- Fill and overflow:
  - Push 4 blocks with out_ready=0 -> level=4, in_ready=0.
  - Push a 5th -> overflow_err=1 and level stays 4.
  - Draining all 16 elements returns the first 4 blocks in order.
- Simultaneous push with the final-element pop at level=1 -> level stays 1 and the new block streams with no bubble.
- Reset mid-stream after element 1 -> all outputs return to reset values at once; a subsequent push streams element 0 first.
- With MAC_RESULT_RELU_EN: element 16'hFF00 outputs 0000, and 16'h0100 outputs 0100.
